// File: rtl/sa_div.sv
// rtl/sa_div.sv - sequential signed divider, sign-magnitude restoring shift-subtract
module sa_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic             sa;
    logic             sb;
    logic             zflag;
    logic             zhold;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    // Partial remainder; its top bit is always zero between iterations, so only
    // the low WIDTH bits are kept and the extra bit lives in the shifted operand.
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Operand magnitudes and one restoring step of the shift-subtract loop.
    always_comb begin
        mag_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
        mag_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
        shifted = {r, q[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        fits    = (shifted >= {1'b0, m});
    end

    // A start arriving in the done cycle is deliberately refused.
    assign ready = (state == IDLE) && !done;

    // Control FSM, datapath registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sa          <= 1'b0;
            sb          <= 1'b0;
            zflag       <= 1'b0;
            zhold       <= 1'b0;
            m           <= '0;
            q           <= '0;
            r           <= '0;
            count       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        sa          <= a[WIDTH-1];
                        sb          <= b[WIDTH-1];
                        m           <= mag_b;
                        q           <= mag_a;
                        r           <= '0;
                        count       <= '0;
                        zflag       <= (b == '0);
                        zhold       <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= (b == '0) ? SIGN : CALC;
                    end
                end
                CALC: begin
                    r     <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    q     <= {q[WIDTH-2:0], fits};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    // Divide-by-zero results are published one edge later so
                    // that case has a fixed two-cycle latency.
                    if (zflag && !zhold) begin
                        zhold <= 1'b1;
                    end else begin
                        if (zflag) begin
                            // q still holds |a|, so re-signing it restores a.
                            quotient  <= '1;
                            remainder <= sa ? (~q + 1'b1) : q;
                        end else begin
                            quotient  <= (sa ^ sb) ? (~q + 1'b1) : q;
                            remainder <= sa ? (~r + 1'b1) : r;
                        end
                        div_by_zero <= zflag;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_div.sv
// tb/tb_sa_div.sv - self-checking bench for sa_div
module tb_sa_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int nvec = 0;
    int nerr = 0;

    sa_div #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed truncating division evaluated in 64-bit arithmetic.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (y == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = x;
            dz = 1'b1;
        end else begin
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
            dz = 1'b0;
        end
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready) begin
            nerr++;
            $display("FAIL wait_ready: got ready=0 expected 1");
        end
    endtask

    // Counts edges until done; returns 101 if it never arrives.
    task automatic wait_done(output int lat, output logic rdy_bad);
        rdy_bad = ready;
        lat = 101;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (ready) rdy_bad = 1'b1;
        end
        if (done && ready) rdy_bad = 1'b1;
    endtask

    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat);
        int   lat;
        logic rdy_bad;
        wait_ready();
        a = ta; b = tb_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        wait_done(lat, rdy_bad);
        nvec++;
        chk("latency", 32'(lat), 32'(elat));
        chk("ready_low_while_busy", {31'd0, rdy_bad}, 32'd0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after_done", {31'd0, ready}, 32'd1);
        chk("quotient_held", quotient, eq);
        chk("remainder_held", remainder, er);
    endtask

    initial begin
        int   lat;
        logic rdy_bad;
        logic [31:0] mq;
        logic [31:0] mr;
        logic        mdz;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        saw_done;

        tbl[0]  = '{32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 33};
        tbl[1]  = '{32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33};
        tbl[2]  = '{32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33};
        tbl[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33};
        tbl[4]  = '{32'd5,         32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        tbl[5]  = '{32'd9,         32'd3,          32'd3,          32'd0,          1'b0, 33};
        tbl[6]  = '{32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
        tbl[7]  = '{32'h8000_0000, 32'd1,          32'h8000_0000,  32'd0,          1'b0, 33};
        tbl[8]  = '{32'd7,         32'h8000_0000,  32'd0,          32'd7,          1'b0, 33};
        tbl[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
        tbl[10] = '{32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 2};
        tbl[11] = '{32'd0,         32'hFFFF_FFFD,  32'd0,          32'd0,          1'b0, 33};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat);
        end

        // Second start while busy is ignored
        wait_ready();
        a = 32'd10; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a = 32'd50; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, rdy_bad);
        nvec++;
        chk("busy_start_latency", 32'(lat), 32'd28);
        chk("busy_start_quotient", quotient, 32'd3);
        chk("busy_start_remainder", remainder, 32'd1);

        // Start held from the done cycle: refused once, then accepted
        a = 32'd20; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        nvec++;
        chk("done_cycle_start_refused", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_start_accepted", {31'd0, ready}, 32'd0);
        wait_done(lat, rdy_bad);
        chk("held_start_latency", 32'(lat), 32'd33);
        chk("held_start_quotient", quotient, 32'd5);
        chk("held_start_remainder", remainder, 32'd0);

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        nvec++;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
        run_div(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 33);

        // Randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 20);
                3:       rb = -$urandom_range(1, 20);
                4:       ra = $urandom_range(0, 200);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 4) rb = 32'd0;
            if (rb === 32'hx) rb = $urandom;
            model(ra, rb, mq, mr, mdz);
            run_div(ra, rb, mq, mr, mdz, mdz ? 2 : 33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
